// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter that shares one spi_mem Wishbone slave port between two masters.
// It keeps one transaction in flight, and a watchdog terminates transactions the slave never acks.
//   state   | meaning
//   ST_IDLE | no transaction on the slave port; evaluate eligible masters every edge
//   ST_BUSY | request latched on s_*; wait for s_ack or the watchdog terminal count
module spi_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter logic [31:0] ERR_DATA       = 32'hFFFFFFFF
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic [31:0] m0_adr,
   input  logic [31:0] m0_dat,
   input  logic [3:0]  m0_sel,
   input  logic        m0_we,
   input  logic        m0_stb,
   output logic [31:0] m0_rdt,
   output logic        m0_ack,
   input  logic [31:0] m1_adr,
   input  logic [31:0] m1_dat,
   input  logic [3:0]  m1_sel,
   input  logic        m1_we,
   input  logic        m1_stb,
   output logic [31:0] m1_rdt,
   output logic        m1_ack,
   output logic [31:0] s_adr,
   output logic [31:0] s_dat,
   output logic [3:0]  s_sel,
   output logic        s_we,
   output logic        s_stb,
   input  logic [31:0] s_rdt,
   input  logic        s_ack,
   output logic        timeout_err
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] TC_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_owner_q, last_owner_d;
   logic [1:0]  need_drop_q, need_drop_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] s_adr_q, s_adr_d;
   logic [31:0] s_dat_q, s_dat_d;
   logic [3:0]  s_sel_q, s_sel_d;
   logic        s_we_q, s_we_d;
   logic        s_stb_q, s_stb_d;
   logic [31:0] m0_rdt_q, m0_rdt_d;
   logic [31:0] m1_rdt_q, m1_rdt_d;
   logic        m0_ack_q, m0_ack_d;
   logic        m1_ack_q, m1_ack_d;
   logic        timeout_err_q, timeout_err_d;

   logic [1:0]  elig;
   logic        grant;
   logic        wd_fire;
   logic [31:0] ret_data;

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_owner_d  = last_owner_q;
      cnt_d         = cnt_q;
      s_adr_d       = s_adr_q;
      s_dat_d       = s_dat_q;
      s_sel_d       = s_sel_q;
      s_we_d        = s_we_q;
      s_stb_d       = s_stb_q;
      m0_rdt_d      = m0_rdt_q;
      m1_rdt_d      = m1_rdt_q;
      m0_ack_d      = 1'b0;
      m1_ack_d      = 1'b0;
      timeout_err_d = 1'b0;
      // A served master must drop stb once before it can be granted again.
      need_drop_d   = need_drop_q & {m1_stb, m0_stb};
      elig          = {m1_stb & ~need_drop_q[1], m0_stb & ~need_drop_q[0]};
      grant         = (elig == 2'b11) ? ~last_owner_q : elig[1];
      wd_fire       = WD_EN && (cnt_q == TC_LAST);
      ret_data      = s_ack ? s_rdt : ERR_DATA;

      case (state_q)
         ST_IDLE: begin
            if (elig != 2'b00) begin
               s_adr_d = grant ? m1_adr : m0_adr;
               s_dat_d = grant ? m1_dat : m0_dat;
               s_sel_d = grant ? m1_sel : m0_sel;
               s_we_d  = grant ? m1_we  : m0_we;
               s_stb_d = 1'b1;
               owner_d = grant;
               cnt_d   = 16'd0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q + 16'd1;
            if (s_ack || wd_fire) begin
               s_stb_d       = 1'b0;
               timeout_err_d = ~s_ack;
               last_owner_d  = owner_q;
               state_d       = ST_IDLE;
               if (owner_q) begin
                  m1_rdt_d       = ret_data;
                  m1_ack_d       = 1'b1;
                  need_drop_d[1] = 1'b1;
               end else begin
                  m0_rdt_d       = ret_data;
                  m0_ack_d       = 1'b1;
                  need_drop_d[0] = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q       <= ST_IDLE;
         owner_q       <= 1'b0;
         last_owner_q  <= 1'b1;
         need_drop_q   <= 2'b00;
         cnt_q         <= 16'd0;
         s_adr_q       <= 32'd0;
         s_dat_q       <= 32'd0;
         s_sel_q       <= 4'd0;
         s_we_q        <= 1'b0;
         s_stb_q       <= 1'b0;
         m0_rdt_q      <= 32'd0;
         m1_rdt_q      <= 32'd0;
         m0_ack_q      <= 1'b0;
         m1_ack_q      <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_owner_q  <= last_owner_d;
         need_drop_q   <= need_drop_d;
         cnt_q         <= cnt_d;
         s_adr_q       <= s_adr_d;
         s_dat_q       <= s_dat_d;
         s_sel_q       <= s_sel_d;
         s_we_q        <= s_we_d;
         s_stb_q       <= s_stb_d;
         m0_rdt_q      <= m0_rdt_d;
         m1_rdt_q      <= m1_rdt_d;
         m0_ack_q      <= m0_ack_d;
         m1_ack_q      <= m1_ack_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign s_adr       = s_adr_q;
   assign s_dat       = s_dat_q;
   assign s_sel       = s_sel_q;
   assign s_we        = s_we_q;
   assign s_stb       = s_stb_q;
   assign m0_rdt      = m0_rdt_q;
   assign m1_rdt      = m1_rdt_q;
   assign m0_ack      = m0_ack_q;
   assign m1_ack      = m1_ack_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter, using a small word-addressed memory as the slave.
// The slave can be set to ack at once, to never ack, or to take a forced ack.
module tb_spi_mem_arbiter;

   logic        wb_clk, wb_rst;
   logic [31:0] m0_adr, m0_dat, m0_rdt, m1_adr, m1_dat, m1_rdt;
   logic [3:0]  m0_sel, m1_sel, s_sel;
   logic        m0_we, m0_stb, m0_ack, m1_we, m1_stb, m1_ack;
   logic [31:0] s_adr, s_dat, s_rdt;
   logic        s_we, s_stb, s_ack, timeout_err;

   logic        auto_ack, manual_ack;
   logic [31:0] mem [0:7];
   int          n_cmp = 0;
   int          n_err = 0;
   int          stb_rises = 0;
   int          terr_count = 0;
   int          snap;
   logic        stb_prev = 1'b0;

   spi_mem_arbiter #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'hFFFFFFFF)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .m0_adr(m0_adr), .m0_dat(m0_dat), .m0_sel(m0_sel), .m0_we(m0_we), .m0_stb(m0_stb),
      .m0_rdt(m0_rdt), .m0_ack(m0_ack),
      .m1_adr(m1_adr), .m1_dat(m1_dat), .m1_sel(m1_sel), .m1_we(m1_we), .m1_stb(m1_stb),
      .m1_rdt(m1_rdt), .m1_ack(m1_ack),
      .s_adr(s_adr), .s_dat(s_dat), .s_sel(s_sel), .s_we(s_we), .s_stb(s_stb),
      .s_rdt(s_rdt), .s_ack(s_ack), .timeout_err(timeout_err)
   );

   initial begin
      wb_clk = 1'b0;
      forever #5 wb_clk = ~wb_clk;
   end

   assign s_ack = (auto_ack & s_stb) | manual_ack;
   assign s_rdt = mem[s_adr[4:2]];

   always @(posedge wb_clk) begin
      if (!wb_rst && s_stb && s_ack && s_we)
         for (int b = 0; b < 4; b++)
            if (s_sel[b]) mem[s_adr[4:2]][8*b +: 8] = s_dat[8*b +: 8];
      if (s_stb && !stb_prev) stb_rises++;
      stb_prev = s_stb;
      if (timeout_err) terr_count++;
   end

   task automatic tick();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic drv_m0(input logic stb, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
      m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = sel;
   endtask

   task automatic drv_m1(input logic stb, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
      m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = sel;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      wb_rst = 1'b1; auto_ack = 1'b1; manual_ack = 1'b0;
      drv_m0(0, 0, 0, 0, 0);
      drv_m1(0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) mem[i] = 32'hA0000000 + i;
      tick(); tick();
      check("rst_s_stb", s_stb, 0);
      check("rst_m0_ack", m0_ack, 0);
      check("rst_m1_ack", m1_ack, 0);
      check("rst_terr", timeout_err, 0);
      check("rst_m0_rdt", m0_rdt, 0);
      wb_rst = 1'b0;

      // m0 write then read of 0x8
      drv_m0(1, 1, 32'h8, 32'h28201810, 4'hF);
      tick();
      check("w_s_stb", s_stb, 1);
      check("w_s_adr", s_adr, 32'h8);
      check("w_s_dat", s_dat, 32'h28201810);
      check("w_s_sel", s_sel, 4'hF);
      check("w_s_we", s_we, 1);
      tick();
      check("w_m0_ack", m0_ack, 1);
      check("w_m1_ack", m1_ack, 0);
      check("w_s_stb_drop", s_stb, 0);
      drv_m0(0, 0, 32'h8, 0, 4'hF);
      tick();
      check("w_m0_ack_pulse", m0_ack, 0);
      drv_m0(1, 0, 32'h8, 0, 4'hF);
      tick();
      check("r_s_stb", s_stb, 1);
      check("r_s_we", s_we, 0);
      tick();
      check("r_m0_ack", m0_ack, 1);
      check("r_m0_rdt", m0_rdt, 32'h28201810);
      check("r_m1_ack", m1_ack, 0);
      drv_m0(0, 0, 0, 0, 4'hF);
      tick();

      // simultaneous requests after reset, then alternation
      wb_rst = 1'b1;
      tick();
      wb_rst = 1'b0;
      drv_m0(1, 0, 32'h0, 0, 4'hF);
      drv_m1(1, 0, 32'h4, 0, 4'hF);
      tick();
      check("tie_g0_adr", s_adr, 32'h0);
      check("tie_g0_stb", s_stb, 1);
      tick();
      check("tie_m0_ack", m0_ack, 1);
      check("tie_m1_ack0", m1_ack, 0);
      check("tie_m0_rdt", m0_rdt, 32'hA0000000);
      m0_stb = 1'b0;
      tick();
      check("tie_g1_adr", s_adr, 32'h4);
      check("tie_g1_m0_ack", m0_ack, 0);
      m0_stb = 1'b1;
      tick();
      check("tie_m1_ack", m1_ack, 1);
      check("tie_m1_rdt", m1_rdt, 32'hA0000001);
      m1_stb = 1'b0;
      tick();
      check("tie_g2_adr", s_adr, 32'h0);
      m1_stb = 1'b1;
      tick();
      check("tie_g2_m0_ack", m0_ack, 1);
      m0_stb = 1'b0;
      tick();
      check("tie_g3_adr", s_adr, 32'h4);
      check("tie_g3_stb", s_stb, 1);
      tick();
      check("tie_g3_m1_ack", m1_ack, 1);
      m1_stb = 1'b0;
      tick();

      // m1 holds stb two cycles past its ack
      snap = stb_rises;
      drv_m1(1, 0, 32'hC, 0, 4'hF);
      tick();
      tick();
      check("hold_m1_ack", m1_ack, 1);
      tick();
      check("hold_stb_a", s_stb, 0);
      check("hold_ack_pulse", m1_ack, 0);
      tick();
      check("hold_stb_b", s_stb, 0);
      m1_stb = 1'b0;
      tick();
      check("hold_stb_c", s_stb, 0);
      tick();
      check("hold_pulses", stb_rises - snap, 1);

      // partial write via m1, then full read back
      drv_m1(1, 1, 32'h10, 32'hDEADBEEF, 4'b1100);
      tick();
      check("pw_s_sel", s_sel, 4'b1100);
      check("pw_s_we", s_we, 1);
      check("pw_s_adr", s_adr, 32'h10);
      tick();
      check("pw_m1_ack", m1_ack, 1);
      m1_stb = 1'b0;
      tick();
      drv_m1(1, 0, 32'h10, 0, 4'hF);
      tick();
      tick();
      check("pr_m1_ack", m1_ack, 1);
      check("pr_m1_rdt", m1_rdt, 32'hDEAD0004);
      check("pr_m0_rdt_hold", m0_rdt, 32'hA0000000);
      check("pr_m0_ack", m0_ack, 0);
      m1_stb = 1'b0;
      tick();

      // watchdog: slave never acks
      auto_ack = 1'b0;
      snap = terr_count;
      drv_m0(1, 0, 32'h14, 0, 4'hF);
      tick();
      check("wd_grant", s_stb, 1);
      repeat (15) tick();
      check("wd_stb_15", s_stb, 1);
      check("wd_ack_15", m0_ack, 0);
      check("wd_terr_15", timeout_err, 0);
      tick();
      check("wd_stb_16", s_stb, 0);
      check("wd_ack_16", m0_ack, 1);
      check("wd_rdt_16", m0_rdt, 32'hFFFFFFFF);
      check("wd_terr_16", timeout_err, 1);
      check("wd_m1_rdt", m1_rdt, 32'hDEAD0004);
      m0_stb = 1'b0;
      tick();
      check("wd_terr_pulse", timeout_err, 0);
      check("wd_terr_count", terr_count - snap, 1);
      auto_ack = 1'b1;
      drv_m0(1, 0, 32'h0, 0, 4'hF);
      tick();
      tick();
      check("wd_next_ack", m0_ack, 1);
      check("wd_next_rdt", m0_rdt, 32'hA0000000);
      check("wd_next_terr", timeout_err, 0);
      m0_stb = 1'b0;
      tick();

      // reset during BUSY, late ack, post-reset tie
      auto_ack = 1'b0;
      drv_m1(1, 0, 32'h4, 0, 4'hF);
      tick();
      check("mr_grant_adr", s_adr, 32'h4);
      check("mr_grant_stb", s_stb, 1);
      tick();
      wb_rst = 1'b1;
      tick();
      check("mr_s_stb", s_stb, 0);
      check("mr_m0_ack", m0_ack, 0);
      check("mr_m1_ack", m1_ack, 0);
      check("mr_m1_rdt", m1_rdt, 0);
      wb_rst = 1'b0;
      m1_stb = 1'b0;
      manual_ack = 1'b1;
      tick();
      manual_ack = 1'b0;
      check("late_s_stb", s_stb, 0);
      check("late_m0_ack", m0_ack, 0);
      check("late_m1_ack", m1_ack, 0);
      drv_m0(1, 0, 32'h0, 0, 4'hF);
      drv_m1(1, 0, 32'h4, 0, 4'hF);
      tick();
      check("prt_adr", s_adr, 32'h0);
      check("prt_stb", s_stb, 1);
      auto_ack = 1'b1;
      tick();
      check("prt_m0_ack", m0_ack, 1);
      check("prt_m1_ack", m1_ack, 0);
      check("prt_m0_rdt", m0_rdt, 32'hA0000000);
      m0_stb = 1'b0;
      m1_stb = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
Two-master Wishbone arbiter that shares the single spi_mem slave port between two requesters, e.g. CPU ibus and dbus. Round-robin grant, one transaction in flight, and registered capture of the winner's request onto the slave port. Routes the slave's ack and read data back to the owning master only. A watchdog terminates transactions the slave never acks.

Parameters:
TIMEOUT_CYCLES, 4096, cycles in BUSY without s_ack before forced termination; 0 disables the watchdog.
ERR_DATA, 32'hFFFFFFFF, read data returned to the master on a timed-out transaction.

Ports:
wb_clk  in  1  clock, all logic on rising edge
wb_rst  in  1  synchronous, active-high reset
m0_adr  in  32  master 0 byte address
m0_dat  in  32  master 0 write data
m0_sel  in  4  master 0 byte enables
m0_we  in  1  master 0 write enable
m0_stb  in  1  master 0 request
m0_rdt  out  32  master 0 read data
m0_ack  out  1  master 0 ack, one-cycle pulse
m1_adr, m1_dat, m1_sel, m1_we, m1_stb, m1_rdt, m1_ack: same as m0, for master 1
s_adr  out  32  to spi_mem wb_mem_adr
s_dat  out  32  to wb_mem_dat
s_sel  out  4  to wb_mem_sel
s_we  out  1  to wb_mem_we
s_stb  out  1  to wb_mem_stb
s_rdt  in  32  from wb_mem_rdt
s_ack  in  1  from wb_mem_ack
timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset: all outputs 0; state IDLE; owner=0; last_owner=1, so m0 wins the first tie; need_drop[1:0]=0; watchdog counter=0. Reset mid-transaction abandons it immediately and issues no ack.
- Eligibility: mX is eligible when mX_stb=1 and need_drop[X]=0. need_drop[X] is set when mX_ack pulses. It clears on the first edge at which mX_stb is sampled 0.
- IDLE: at each edge the eligible set is evaluated.
  - One eligible: grant it.
  - Both eligible: grant the master other than last_owner.
  - On grant: latch that master's adr, dat, sel and we into s_*; set s_stb=1; owner=X; go to BUSY. s_stb is high in the cycle after the edge that sampled mX_stb.
- BUSY: s_* hold stable. Master inputs are ignored after the grant edge.
  - s_ack sampled 1: s_stb←0, mOWNER_rdt←s_rdt, mOWNER_ack←1 for exactly one cycle, last_owner←owner, need_drop[owner]←1, go to IDLE. The ack reaches the master 1 cycle after s_ack.
  - Counter reaches TIMEOUT_CYCLES-1 with no s_ack: same exit, but rdt←ERR_DATA and timeout_err pulses for 1 cycle. If s_ack and terminal count coincide, s_ack wins: real data, no error.
- The non-owner's ack stays 0 and its rdt holds its previous value. mX_rdt is only updated on mX's own ack.
- s_ack in IDLE is ignored.
- Grant is earliest at the edge after the ack-issuing edge, so at least one idle cycle separates consecutive s_stb pulses. A waiting master is granted at that edge.
- The counter resets on each grant, increments every BUSY cycle, and is 16 bits wide. TIMEOUT_CYCLES must be < 65536.
- sel and we are passed through unmodified, including partial sel such as 4'b0010 and 4'b1100. The arbiter never combines or splits transactions.

Test Plan:
- m0 only: write adr 0x8, dat 0x28201810, sel F, then a read of 0x8 → one s_stb per access, s_* equal the m0 inputs; m0_rdt=0x28201810 one cycle after s_ack; m1_ack stays 0.
- m0_stb and m1_stb rise on the same edge after reset → m0 served first, then m1. With both held and re-raised, grants alternate 0,1,0,1 over 4 transactions.
- m1 holds stb for 2 cycles after its ack, m0 idle → no second grant to m1 until m1_stb is sampled low; exactly one s_stb pulse.
- Partial write sel 4'b1100, adr 0x10 via m1 → s_sel=4'b1100, s_we=1. A subsequent sel-F read returns the updated bytes [31:16] only.
- Stub slave never acks, TIMEOUT_CYCLES=16 → s_stb drops and m0_ack pulses 16 cycles after grant with m0_rdt=0xFFFFFFFF. timeout_err pulses once. The next request is served normally.
- wb_rst asserted mid-BUSY → next cycle s_stb=0, no acks, state IDLE. A late s_ack is ignored, and m0 wins the first post-reset tie.
